// File: rtl/line_move_pkg.sv
// Shared constants and command decode for the line mover.
// Bounce mode is compiled in by defining LINE_MOVE_BOUNCE_EN.
package line_move_pkg;

  localparam int unsigned LINE_LO_DEF = 18;
  localparam int unsigned LINE_HI_DEF = 630;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    CmdHold,
    CmdUp,
    CmdDn,
    CmdBoth
  } move_cmd_e;

  function automatic move_cmd_e decode_cmd(input logic up, input logic dw);
    unique case ({up, dw})
      2'b10:   return CmdUp;
      2'b01:   return CmdDn;
      2'b11:   return CmdBoth;
      default: return CmdHold;
    endcase
  endfunction

endpackage

// File: rtl/line_move_next.sv
// Combinational next coordinate: step arithmetic, clamping to [LO,HI], load clamp and hit flags.
// LINE_MOVE_BOUNCE_EN makes UP+DW travel along the current direction and reflect at the bounds.
module line_move_next
  import line_move_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LO     = LINE_LO_DEF,
  parameter int unsigned HI     = LINE_HI_DEF,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_q,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_dir,
  input  logic              i_up,
  input  logic              i_dw,
  input  logic [STEP_W-1:0] i_step,
  output logic [WIDTH-1:0]  o_ld_val,
  output logic [WIDTH-1:0]  o_q_next,
  output logic              o_move,
  output logic              o_dir_next,
  output logic              o_hit_hi,
  output logic              o_hit_lo
);

  localparam logic [WIDTH:0]   LoExt = (WIDTH + 1)'(LO);
  localparam logic [WIDTH:0]   HiExt = (WIDTH + 1)'(HI);
  localparam logic [WIDTH-1:0] LoVal = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HiVal = WIDTH'(HI);

  move_cmd_e        w_cmd;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic             w_up_hit;
  logic             w_dn_hit;

  always_comb begin
    w_cmd      = decode_cmd(i_up, i_dw);
    w_q_ext    = {1'b0, i_q};
    w_d_ext    = {1'b0, i_d};
    w_step_ext = (WIDTH + 1)'(i_step);
    w_sum      = w_q_ext + w_step_ext;
    w_diff     = w_q_ext - w_step_ext;

    w_up_val = (w_sum > HiExt) ? HiVal : w_sum[WIDTH-1:0];
    // Borrow out of the extra bit means the subtraction went below zero.
    w_dn_val = (w_diff[WIDTH] || (w_diff < LoExt)) ? LoVal : w_diff[WIDTH-1:0];
    w_up_hit = (w_up_val == HiVal) && (i_q != HiVal);
    w_dn_hit = (w_dn_val == LoVal) && (i_q != LoVal);

    if (w_d_ext < LoExt) begin
      o_ld_val = LoVal;
    end else if (w_d_ext > HiExt) begin
      o_ld_val = HiVal;
    end else begin
      o_ld_val = i_d;
    end

    o_move     = 1'b0;
    o_q_next   = i_q;
    o_dir_next = i_dir;
    o_hit_hi   = 1'b0;
    o_hit_lo   = 1'b0;

    unique case (w_cmd)
      CmdUp: begin
        o_move     = 1'b1;
        o_q_next   = w_up_val;
        o_dir_next = DIR_UP;
        o_hit_hi   = w_up_hit;
      end
      CmdDn: begin
        o_move     = 1'b1;
        o_q_next   = w_dn_val;
        o_dir_next = DIR_DN;
        o_hit_lo   = w_dn_hit;
      end
      CmdBoth: begin
`ifdef LINE_MOVE_BOUNCE_EN
        o_move = 1'b1;
        if (i_dir == DIR_UP) begin
          o_q_next = w_up_val;
          o_hit_hi = w_up_hit;
          if (w_up_val == HiVal) o_dir_next = DIR_DN;
        end else begin
          o_q_next = w_dn_val;
          o_hit_lo = w_dn_hit;
          if (w_dn_val == LoVal) o_dir_next = DIR_UP;
        end
`else
        o_move = 1'b0;
`endif
      end
      default: o_move = 1'b0;
    endcase
  end

endmodule

// File: rtl/line_move_counter.sv
// Loadable, clamped up/down coordinate counter for one moving display line.
// Defining LINE_MOVE_BOUNCE_EN enables autonomous bounce on simultaneous UP+DW.
module line_move_counter
  import line_move_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LO     = LINE_LO_DEF,
  parameter int unsigned HI     = LINE_HI_DEF,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              UP,
  input  logic              DW,
  input  logic              LD,
  input  logic [WIDTH-1:0]  D,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  Q,
  output logic              UTC,
  output logic              DTC,
  output logic              hit_hi,
  output logic              hit_lo,
  output logic              dir
);

  localparam logic [WIDTH-1:0] LoVal = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HiVal = WIDTH'(HI);

  logic [WIDTH-1:0] r_q;
  logic             r_dir;
  logic             r_hit_hi;
  logic             r_hit_lo;

  logic [WIDTH-1:0] w_ld_val;
  logic [WIDTH-1:0] w_q_next;
  logic             w_move;
  logic             w_dir_next;
  logic             w_hit_hi;
  logic             w_hit_lo;

  logic [WIDTH-1:0] w_q_d;
  logic             w_dir_d;
  logic             w_hit_hi_d;
  logic             w_hit_lo_d;

  line_move_next #(
    .WIDTH  (WIDTH),
    .LO     (LO),
    .HI     (HI),
    .STEP_W (STEP_W)
  ) u_next (
    .i_q        (r_q),
    .i_d        (D),
    .i_dir      (r_dir),
    .i_up       (UP),
    .i_dw       (DW),
    .i_step     (step),
    .o_ld_val   (w_ld_val),
    .o_q_next   (w_q_next),
    .o_move     (w_move),
    .o_dir_next (w_dir_next),
    .o_hit_hi   (w_hit_hi),
    .o_hit_lo   (w_hit_lo)
  );

  // Load beats movement; pulses only survive one cycle after a landing move.
  always_comb begin
    w_q_d      = r_q;
    w_dir_d    = r_dir;
    w_hit_hi_d = 1'b0;
    w_hit_lo_d = 1'b0;
    if (LD) begin
      w_q_d = w_ld_val;
    end else if (tick && w_move) begin
      w_q_d      = w_q_next;
      w_dir_d    = w_dir_next;
      w_hit_hi_d = w_hit_hi;
      w_hit_lo_d = w_hit_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= LoVal;
      r_dir    <= DIR_UP;
      r_hit_hi <= 1'b0;
      r_hit_lo <= 1'b0;
    end else begin
      r_q      <= w_q_d;
      r_dir    <= w_dir_d;
      r_hit_hi <= w_hit_hi_d;
      r_hit_lo <= w_hit_lo_d;
    end
  end

  assign Q      = r_q;
  assign dir    = r_dir;
  assign hit_hi = r_hit_hi;
  assign hit_lo = r_hit_lo;
  assign UTC    = (r_q == HiVal);
  assign DTC    = (r_q == LoVal);

endmodule

// File: tb/tb_line_move_counter.sv
// Scoreboard bench for line_move_counter: directed scenarios followed by random traffic.
// Expectations for UP+DW with tick follow LINE_MOVE_BOUNCE_EN when it is defined.
module tb_line_move_counter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STEP_W = 4;
  localparam int          LO     = 18;
  localparam int          HI     = 630;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic              UP = 1'b0;
  logic              DW = 1'b0;
  logic              LD = 1'b0;
  logic [WIDTH-1:0]  D = '0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  Q;
  logic              UTC;
  logic              DTC;
  logic              hit_hi;
  logic              hit_lo;
  logic              dir;

  line_move_counter #(
    .WIDTH  (WIDTH),
    .LO     (LO),
    .HI     (HI),
    .STEP_W (STEP_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .UP     (UP),
    .DW     (DW),
    .LD     (LD),
    .D      (D),
    .step   (step),
    .Q      (Q),
    .UTC    (UTC),
    .DTC    (DTC),
    .hit_hi (hit_hi),
    .hit_lo (hit_lo),
    .dir    (dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit dir;
    bit hh;
    bit hl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_q = LO;
  bit   m_dir = 1'b1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model(input bit rst, input bit ld, input int d, input bit up, input bit dw,
                       input bit tk, input int stp, output exp_t e);
    int nq;
    e.hh = 1'b0;
    e.hl = 1'b0;
    if (rst) begin
      m_q   = LO;
      m_dir = 1'b1;
    end else if (ld) begin
      m_q = (d < LO) ? LO : (d > HI) ? HI : d;
    end else if (tk) begin
      bit go_up;
      bit go_dn;
      bit bounce;
      go_up  = up && !dw;
      go_dn  = dw && !up;
      bounce = 1'b0;
`ifdef LINE_MOVE_BOUNCE_EN
      if (up && dw) begin
        bounce = 1'b1;
        go_up  = m_dir;
        go_dn  = !m_dir;
      end
`endif
      if (go_up) begin
        nq = (m_q + stp > HI) ? HI : m_q + stp;
        e.hh = (nq == HI) && (m_q != HI);
        m_dir = bounce ? !(nq == HI) : 1'b1;
        m_q = nq;
      end else if (go_dn) begin
        nq = (m_q - stp < LO) ? LO : m_q - stp;
        e.hl = (nq == LO) && (m_q != LO);
        m_dir = bounce ? (nq == LO) : 1'b0;
        m_q = nq;
      end
    end
    e.q   = m_q;
    e.dir = m_dir;
  endtask

  task automatic cycle(input bit rst, input bit ld, input int d, input bit up, input bit dw,
                       input bit tk, input int stp);
    exp_t e;
    reset = rst;
    LD    = ld;
    D     = WIDTH'(d);
    UP    = up;
    DW    = dw;
    tick  = tk;
    step  = STEP_W'(stp);
    model(rst, ld, d, up, dw, tk, stp, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq("q", int'(Q), e.q);
      check_eq("dir", int'(dir), int'(e.dir));
      check_eq("hit_hi", int'(hit_hi), int'(e.hh));
      check_eq("hit_lo", int'(hit_lo), int'(e.hl));
      check_eq("utc", int'(UTC), int'(e.q == HI));
      check_eq("dtc", int'(DTC), int'(e.q == LO));
    end
  endtask

  initial begin
    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("rst_q", int'(Q), 18);
    check_eq("rst_dtc", int'(DTC), 1);
    check_eq("rst_utc", int'(UTC), 0);
    check_eq("rst_dir", int'(dir), 1);

    // Load clamping at both ends
    cycle(0, 1, 700, 0, 0, 0, 0);
    check_eq("ld_hi_q", int'(Q), 630);
    check_eq("ld_hi_utc", int'(UTC), 1);
    cycle(0, 1, 5, 0, 0, 0, 0);
    check_eq("ld_lo_q", int'(Q), 18);

    // Approach HI, single pulse, then push into the bound
    cycle(0, 1, 620, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 7);
    check_eq("up1_q", int'(Q), 627);
    cycle(0, 0, 0, 1, 0, 1, 7);
    check_eq("up2_q", int'(Q), 630);
    check_eq("up2_hit", int'(hit_hi), 1);
    cycle(0, 0, 0, 0, 0, 0, 7);
    check_eq("idle_hit", int'(hit_hi), 0);
    cycle(0, 0, 0, 1, 0, 1, 7);
    check_eq("up3_q", int'(Q), 630);
    check_eq("up3_hit", int'(hit_hi), 0);

    // Down onto LO; UP+DW without tick does nothing
    cycle(0, 1, 20, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 15);
    check_eq("dn_q", int'(Q), 18);
    check_eq("dn_hit", int'(hit_lo), 1);
    check_eq("dn_dir", int'(dir), 0);
    cycle(0, 0, 0, 1, 1, 0, 15);
    check_eq("both_notick_q", int'(Q), 18);

    // Zero step holds Q but still sets dir
    cycle(0, 1, 200, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 0);
    check_eq("step0_q", int'(Q), 200);
    check_eq("step0_dir", int'(dir), 1);

    // Load beats move; reset afterwards
    cycle(0, 1, 100, 0, 0, 0, 0);
    cycle(0, 1, 300, 1, 0, 1, 5);
    check_eq("ld_pri_q", int'(Q), 300);
    check_eq("ld_pri_hit", int'(hit_hi), 0);
    cycle(1, 1, 400, 1, 0, 1, 5);
    check_eq("rst_pri_q", int'(Q), 18);

    // UP+DW with tick every cycle
    cycle(0, 1, 625, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 8);
`ifdef LINE_MOVE_BOUNCE_EN
    check_eq("bnc1_q", int'(Q), 630);
    check_eq("bnc1_dir", int'(dir), 0);
    check_eq("bnc1_hit", int'(hit_hi), 1);
    cycle(0, 0, 0, 1, 1, 1, 8);
    check_eq("bnc2_q", int'(Q), 622);
    cycle(0, 0, 0, 1, 1, 1, 8);
    check_eq("bnc3_q", int'(Q), 614);
`else
    check_eq("nobnc1_q", int'(Q), 625);
    cycle(0, 0, 0, 1, 1, 1, 8);
    cycle(0, 0, 0, 1, 1, 1, 8);
    check_eq("nobnc3_q", int'(Q), 625);
    check_eq("nobnc3_dir", int'(dir), 1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 800)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_move_counter.md
# line_move_counter

Parametrised, loadable up/down coordinate counter that positions one moving line of the Wild Cube display. It generalises the fixed 16-bit line mover: configurable width and bounds, a per-move step size, frame-tick gating, clamping at the bounds, registered boundary-hit pulses and an optional autonomous bounce mode. It sits between the button/switch front end and the VGA line-drawing logic, and supplies the line's Y coordinate each frame.

## Interface
- WIDTH, 16, coordinate width in bits
- LO, 18, lower bound on the coordinate (inclusive)
- HI, 630, upper bound on the coordinate (inclusive); 0 ≤ LO < HI < 2^WIDTH
- STEP_W, 4, width of the step input; STEP_W < WIDTH
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  movement strobe, one cycle per frame; movement occurs only when tick=1
- UP  in  1  move-up request
- DW  in  1  move-down request
- LD  in  1  load request
- D  in  WIDTH  load value
- step  in  STEP_W  increment per move; 0 means hold
- Q  out  WIDTH  current coordinate (registered)
- UTC  out  1  combinational flag, Q == HI
- DTC  out  1  combinational flag, Q == LO
- hit_hi  out  1  registered one-cycle pulse: a move has just landed Q on HI
- hit_lo  out  1  registered one-cycle pulse: a move has just landed Q on LO
- dir  out  1  registered direction, 1 = up

## Operation
- Priority: reset > LD > move > hold.
- Reset: Q=LO, dir=1, hit_hi=0, hit_lo=0.
- LD: Q ← clamp(D, LO, HI). LD does not depend on tick. hit pulses are 0 and dir is unchanged.
- Move (tick=1, LD=0):
  - UP=1, DW=0: Q ← min(Q+step, HI); dir ← 1.
  - DW=1, UP=0: Q ← max(Q−step, LO); dir ← 0.
  - UP=DW=0: hold.
  - UP=DW=1: hold, unless LINE_MOVE_BOUNCE_EN is defined (see Configuration).
- Arithmetic: compute the next value in WIDTH+1 bits, then clamp. Q never wraps and never leaves [LO,HI] after a move or load.
- hit_hi=1 in the cycle after a move whose result equals HI while the prior Q≠HI. hit_lo is the same for LO. Otherwise each pulse is 0.
- Moving further into a bound (for example UP with Q=HI) holds Q and produces no pulse.
- step=0 during a move: Q holds and no pulse fires. dir still updates.

## Timing
- Q, dir, hit_hi and hit_lo update on the rising clk edge that samples the command. Latency is 1 cycle.
- UTC and DTC follow Q combinationally, in the same cycle as Q.
- tick is sampled only in the cycle in which it is high. A tick held high for N cycles produces N moves.
- Reset asserted during any operation wins on that edge. LD and tick in that cycle are discarded.

## Configuration
- LINE_MOVE_BOUNCE_EN defined:
  - UP=DW=1 with tick=1 moves in direction dir by step, using the same clamping.
  - If the clamped result equals the bound in the direction of travel, dir flips on the same edge and the hit pulse fires.
  - Example: HI=630, Q=625, step=8, dir=1 → Q=630, dir=0, hit_hi=1.
- LINE_MOVE_BOUNCE_EN undefined: UP=DW=1 holds, and dir changes only on single-direction commands.

## Structure
- Package line_move_pkg:
  - default bound constants LINE_LO_DEF=18 and LINE_HI_DEF=630
  - direction encoding DIR_UP=1'b1, DIR_DN=1'b0
- One sub-module, line_move_next: combinational next-value, clamp and bound-hit calculation, instantiated once. The top level holds the Q, dir and pulse registers and the priority logic.

## Test plan
- Reset with defaults → Q=18, DTC=1, UTC=0, dir=1, no pulses.
- LD=1, D=700 → Q=630 and UTC=1. Then LD=1, D=5 → Q=18.
- Q=620, step=7, UP+tick twice → Q=627, then 630 with hit_hi=1 for exactly one cycle. A third UP+tick → Q=630, no pulse.
- Q=20, step=15, DW+tick → Q=18, hit_lo=1, dir=0. UP+DW without tick → no change.
- Q=100, LD=1 with D=300 and UP+tick in the same cycle → Q=300, no pulse. Reset in the cycle after → Q=18.
- Bounce build: Q=625, step=8, UP=DW=1, tick every cycle → sequence 630 (dir=0, hit_hi), 622, 614, and so on. Non-bounce build with the same stimulus → Q stays 625.
